// File: rtl/ipif_master_pkg.sv
// Shared types and constants for the AXI Master Burst IPIF initiator.
package ipif_master_pkg;

  // Copy-engine state; exported on the debug port of the top level.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_RD_CMPLT = 3'd3,
    ST_WR_REQ   = 3'd4,
    ST_WR_DATA  = 3'd5,
    ST_WR_CMPLT = 3'd6
  } state_t;

  localparam int         BEAT_BYTES      = 8;
  localparam logic [7:0] IPIF_BE         = 8'hFF;
  localparam logic       IPIF_TYPE_BURST = 1'b1;
  localparam logic [7:0] IPIF_REM        = 8'h00;

  // Bits needed to index the beats of one burst (at least 1).
  function automatic int beat_cnt_w(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/burst_fifo.sv
// One-burst show-ahead buffer between the read and write LocalLink streams.
module burst_fifo
  import ipif_master_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = beat_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // Full/empty guards make stray push/pop requests harmless.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful while count covers them.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr_burst_copy_master.sv
// Copies num_bursts fixed-size bursts from src_addr to dst_addr through the
// IPIF master ports: read command, buffer the read stream, write command,
// replay the buffer on the write stream, repeat.
//
// Handshakes: a command is accepted on a cycle where req and cmdack are both
// high; a stream beat moves on a cycle where src_rdy_n and dst_rdy_n are both
// low. The source holds data, sof_n and eof_n stable while it waits.
module ddr_burst_copy_master
  import ipif_master_pkg::*;
#(
  parameter int BURST_BEATS = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       num_bursts,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              ip2bus_mstrd_req,
  output logic              ip2bus_mstwr_req,
  output logic [ADDR_W-1:0] ip2bus_mst_addr,
  output logic [19:0]       ip2bus_mst_length,
  output logic [7:0]        ip2bus_mst_be,
  output logic              ip2bus_mst_type,
  output logic              ip2bus_mst_lock,
  output logic              ip2bus_mst_reset,
  input  logic              bus2ip_mst_cmdack,
  input  logic              bus2ip_mst_cmplt,
  input  logic              bus2ip_mst_error,
  input  logic [63:0]       bus2ip_mstrd_d,
  input  logic              bus2ip_mstrd_sof_n,
  input  logic              bus2ip_mstrd_eof_n,
  input  logic              bus2ip_mstrd_src_rdy_n,
  output logic              ip2bus_mstrd_dst_rdy_n,
  output logic [63:0]       ip2bus_mstwr_d,
  output logic [7:0]        ip2bus_mstwr_rem,
  output logic              ip2bus_mstwr_sof_n,
  output logic              ip2bus_mstwr_eof_n,
  output logic              ip2bus_mstwr_src_rdy_n,
  input  logic              bus2ip_mstwr_dst_rdy_n,
  output state_t            dbg_state
);

  localparam int                CW          = beat_cnt_w(BURST_BEATS);
  localparam logic [CW-1:0]     LAST_BEAT   = CW'(BURST_BEATS - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * BEAT_BYTES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [15:0]       count;
  logic [CW-1:0]     rd_beat, wr_beat;
  logic              cmplt_seen, cmplt_err_seen;
  logic              done_q, error_q;

  logic              fifo_full, fifo_empty;
  logic [63:0]       fifo_head;
  logic              rd_xfer, wr_xfer, wr_active, proto_err;
  logic              cmplt_evt, cmplt_err;
  logic              accept_start, abort, finish, advance;

  // Stream transfer qualifiers and completion events.
  assign rd_xfer   = (state == ST_RD_DATA) && !fifo_full && !bus2ip_mstrd_src_rdy_n;
  assign wr_active = (state == ST_WR_DATA) && !fifo_empty;
  assign wr_xfer   = wr_active && !bus2ip_mstwr_dst_rdy_n;
  assign proto_err = rd_xfer &&
                     ((!bus2ip_mstrd_eof_n && (rd_beat != LAST_BEAT)) ||
                      (!bus2ip_mstrd_sof_n && (rd_beat != '0)));
  assign cmplt_evt = bus2ip_mst_cmplt || cmplt_seen;
  assign cmplt_err = (bus2ip_mst_cmplt && bus2ip_mst_error) || cmplt_err_seen;

  burst_fifo #(
    .DEPTH  (BURST_BEATS),
    .DATA_W (64)
  ) u_buf (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (abort),
    .push      (rd_xfer),
    .push_data (bus2ip_mstrd_d),
    .pop       (wr_xfer),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the one-cycle events that steer the datapath.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    abort        = 1'b0;
    finish       = 1'b0;
    advance      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          if (num_bursts == '0) finish = 1'b1;
          else                  state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (bus2ip_mst_cmdack) state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (proto_err || (bus2ip_mst_cmplt && bus2ip_mst_error)) abort = 1'b1;
        else if (rd_xfer && (rd_beat == LAST_BEAT))             state_nxt = ST_RD_CMPLT;
      end
      ST_RD_CMPLT: begin
        if (cmplt_err)      abort = 1'b1;
        else if (cmplt_evt) state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (bus2ip_mst_cmdack) state_nxt = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (wr_xfer && (wr_beat == LAST_BEAT)) state_nxt = ST_WR_CMPLT;
      end
      ST_WR_CMPLT: begin
        if (cmplt_err) begin
          abort = 1'b1;
        end else if (cmplt_evt) begin
          advance = 1'b1;
          if (count == 16'd1) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RD_REQ;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Pointers, burst count, beat counters, early-cmplt capture and status.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      src_ptr        <= '0;
      dst_ptr        <= '0;
      count          <= '0;
      rd_beat        <= '0;
      wr_beat        <= '0;
      cmplt_seen     <= 1'b0;
      cmplt_err_seen <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      done_q <= finish || abort;
      if (accept_start) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        count   <= num_bursts;
        error_q <= 1'b0;
      end
      if (abort) error_q <= 1'b1;
      if (advance) begin
        src_ptr <= src_ptr + BURST_BYTES;
        dst_ptr <= dst_ptr + BURST_BYTES;
        count   <= count - 16'd1;
      end
      if (state != ST_RD_DATA) rd_beat <= '0;
      else if (rd_xfer)        rd_beat <= rd_beat + 1'b1;
      if (state != ST_WR_DATA) wr_beat <= '0;
      else if (wr_xfer)        wr_beat <= wr_beat + 1'b1;
      // A cmplt that beats the stream to its end is remembered for the
      // following *_CMPLT state; every other state clears the memory.
      if ((state == ST_RD_DATA) || (state == ST_WR_DATA)) begin
        cmplt_seen     <= cmplt_seen || bus2ip_mst_cmplt;
        cmplt_err_seen <= cmplt_err_seen || (bus2ip_mst_cmplt && bus2ip_mst_error);
      end else begin
        cmplt_seen     <= 1'b0;
        cmplt_err_seen <= 1'b0;
      end
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy                   = (state != ST_IDLE);
    done                   = done_q;
    error                  = error_q;
    ip2bus_mstrd_req       = (state == ST_RD_REQ);
    ip2bus_mstwr_req       = (state == ST_WR_REQ);
    ip2bus_mst_addr        = '0;
    if (state == ST_RD_REQ) ip2bus_mst_addr = src_ptr;
    if (state == ST_WR_REQ) ip2bus_mst_addr = dst_ptr;
    ip2bus_mst_length      = 20'(BURST_BEATS * BEAT_BYTES);
    ip2bus_mst_be          = IPIF_BE;
    ip2bus_mst_type        = IPIF_TYPE_BURST;
    ip2bus_mst_lock        = 1'b0;
    ip2bus_mst_reset       = 1'b0;
    ip2bus_mstrd_dst_rdy_n = !((state == ST_RD_DATA) && !fifo_full);
    ip2bus_mstwr_d         = wr_active ? fifo_head : 64'd0;
    ip2bus_mstwr_rem       = IPIF_REM;
    ip2bus_mstwr_src_rdy_n = !wr_active;
    ip2bus_mstwr_sof_n     = !(wr_active && (wr_beat == '0));
    ip2bus_mstwr_eof_n     = !(wr_active && (wr_beat == LAST_BEAT));
    dbg_state              = state;
  end

endmodule
